// File: rtl/muldiv_pkg.sv
// Shared types for the multiply/divide unit: funct3 op encodings, FSM states
// and the divide special-case detector.
package muldiv_pkg;

    localparam int XLEN_DEFAULT = 32;

    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_e;

    typedef enum logic [1:0] {
        SPEC_NONE,
        SPEC_DIV0,
        SPEC_OVF
    } special_e;

    // Divide-by-zero wins over signed overflow; multiplies are never special.
    function automatic special_e special_kind(input op_e op, input logic b_zero, input logic ovf_operands);
        if (!(op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU}))
            return SPEC_NONE;
        if (b_zero)
            return SPEC_DIV0;
        if (ovf_operands && (op inside {OP_DIV, OP_REM}))
            return SPEC_OVF;
        return SPEC_NONE;
    endfunction

endpackage

// File: rtl/muldiv_unit_addsub.sv
// Parametrised adder/subtractor with carry out; a carry of 1 in subtract
// mode means a >= b (no borrow).
module addsub_n #(
    parameter int W = 33
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         sub,
    output logic [W-1:0] sum,
    output logic         carry_out
);

    always_comb begin
        {carry_out, sum} = {1'b0, a} + {1'b0, b ^ {W{sub}}} + {{W{1'b0}}, sub};
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M/RV64M multiply/divide unit with valid/ready handshakes and flush.
// Optional `MULDIV_FAST_MUL_EN: multiplies complete in one cycle via an array product.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [2:0]      i_op,
    input  logic [XLEN-1:0] i_op_a,
    input  logic [XLEN-1:0] i_op_b,
    input  logic            i_flush,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [XLEN-1:0] o_result,
    output logic            o_busy
);

    localparam int CW = $clog2(XLEN);
    localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

    state_e          state_q, state_d;
    op_e             op_q, op_in;
    logic            sign_q;
    logic [CW-1:0]   cnt_q;
    logic [XLEN-1:0] opnd_q, hi_q, lo_q, result_q;

    logic            accept, single_cycle;
    logic            a_signed, b_signed, sa, sb, in_sign;
    logic [XLEN-1:0] mag_a, mag_b, special_res, direct_res;
    special_e        kind;

    assign op_in  = op_e'(i_op);
    assign accept = (state_q == IDLE) && i_valid && !i_flush;

    // Request decode: operand magnitudes, result sign and the one-cycle results.
    always_comb begin
        a_signed = op_in inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
        b_signed = op_in inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
        sa       = a_signed && i_op_a[XLEN-1];
        sb       = b_signed && i_op_b[XLEN-1];
        mag_a    = sa ? (~i_op_a + 1'b1) : i_op_a;
        mag_b    = sb ? (~i_op_b + 1'b1) : i_op_b;
        in_sign  = (op_in inside {OP_REM, OP_REMU}) ? sa : (sa ^ sb);
        kind     = special_kind(op_in, i_op_b == '0,
                                (i_op_a == {1'b1, {(XLEN-1){1'b0}}}) && (i_op_b == '1));
        case (kind)
            SPEC_DIV0: special_res = i_op[1] ? i_op_a : '1;
            SPEC_OVF:  special_res = i_op[1] ? '0 : i_op_a;
            default:   special_res = '0;
        endcase
    end

`ifdef MULDIV_FAST_MUL_EN
    logic [2*XLEN-1:0] ext_a, ext_b, fast_prod;

    always_comb begin
        ext_a        = a_signed ? {{XLEN{i_op_a[XLEN-1]}}, i_op_a} : {{XLEN{1'b0}}, i_op_a};
        ext_b        = b_signed ? {{XLEN{i_op_b[XLEN-1]}}, i_op_b} : {{XLEN{1'b0}}, i_op_b};
        fast_prod    = ext_a * ext_b;
        single_cycle = (kind != SPEC_NONE) || !i_op[2];
        if (kind != SPEC_NONE)
            direct_res = special_res;
        else if (op_in == OP_MUL)
            direct_res = fast_prod[XLEN-1:0];
        else
            direct_res = fast_prod[2*XLEN-1:XLEN];
    end
`else
    always_comb begin
        single_cycle = (kind != SPEC_NONE);
        direct_res   = special_res;
    end
`endif

    logic            is_div_q, step_sub, step_co, neg_co, neg_inc, unused_neg;
    logic [XLEN:0]   step_a, step_b, step_sum, neg_a, neg_b, neg_sum;
    logic [XLEN-1:0] hi_n, lo_n, sel, final_res;

    // Multiply keeps {hi,lo} as the product accumulator; divide keeps the
    // remainder in hi and shifts dividend bits out / quotient bits into lo.
    always_comb begin
        is_div_q = op_q inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
        step_sub = is_div_q;
        step_a   = is_div_q ? {hi_q, lo_q[XLEN-1]} : {1'b0, hi_q};
        step_b   = (is_div_q || lo_q[0]) ? {1'b0, opnd_q} : '0;
    end

    addsub_n #(.W(XLEN + 1)) u_step (
        .a         (step_a),
        .b         (step_b),
        .sub       (step_sub),
        .sum       (step_sum),
        .carry_out (step_co)
    );

    // A negated high half only takes the +1 carry when the low half is zero.
    always_comb begin
        if (is_div_q) begin
            hi_n = step_co ? step_sum[XLEN-1:0] : {hi_q[XLEN-2:0], lo_q[XLEN-1]};
            lo_n = {lo_q[XLEN-2:0], step_co};
        end else begin
            hi_n = step_sum[XLEN:1];
            lo_n = {step_sum[0], lo_q[XLEN-1:1]};
        end
        sel     = (op_q inside {OP_MUL, OP_DIV, OP_DIVU}) ? lo_n : hi_n;
        neg_inc = (op_q inside {OP_MULH, OP_MULHSU, OP_MULHU}) ? (lo_n == '0) : 1'b1;
        neg_a   = {1'b0, ~sel};
        neg_b   = {{XLEN{1'b0}}, neg_inc};
    end

    addsub_n #(.W(XLEN + 1)) u_neg (
        .a         (neg_a),
        .b         (neg_b),
        .sub       (1'b0),
        .sum       (neg_sum),
        .carry_out (neg_co)
    );

    assign unused_neg = neg_co ^ neg_sum[XLEN];
    assign final_res  = sign_q ? neg_sum[XLEN-1:0] : sel;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = single_cycle ? DONE : CALC;
            CALC:    if (i_flush) state_d = IDLE;
                     else if (cnt_q == LAST) state_d = DONE;
            DONE:    if (i_flush || i_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        o_ready = (state_q == IDLE);
        o_busy  = (state_q != IDLE);
        o_valid = (state_q == DONE);
    end

    // Operands are captured only on accept; a flushed calculation never writes the result.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            op_q     <= OP_MUL;
            sign_q   <= 1'b0;
            cnt_q    <= '0;
            opnd_q   <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            result_q <= '0;
        end else if (accept) begin
            op_q   <= op_in;
            sign_q <= in_sign;
            cnt_q  <= '0;
            hi_q   <= '0;
            if (i_op[2]) begin
                opnd_q <= mag_b;
                lo_q   <= mag_a;
            end else begin
                opnd_q <= mag_a;
                lo_q   <= mag_b;
            end
            if (single_cycle)
                result_q <= direct_res;
        end else if ((state_q == CALC) && !i_flush) begin
            hi_q  <= hi_n;
            lo_q  <= lo_n;
            cnt_q <= cnt_q + CW'(1);
            if (cnt_q == LAST)
                result_q <= final_res;
        end
    end

    assign o_result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit (XLEN=32) against an arithmetic reference model.
// Honours `MULDIV_FAST_MUL_EN for expected multiply latency.
module tb_muldiv_unit;

    logic        i_clk;
    logic        i_rst_n;
    logic        i_valid;
    logic        o_ready;
    logic [2:0]  i_op;
    logic [31:0] i_op_a;
    logic [31:0] i_op_b;
    logic        i_flush;
    logic        o_valid;
    logic        i_ready;
    logic [31:0] o_result;
    logic        o_busy;

    int check_cnt = 0;
    int pass_cnt  = 0;

    muldiv_unit #(.XLEN(32)) dut (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_valid  (i_valid),
        .o_ready  (o_ready),
        .i_op     (i_op),
        .i_op_a   (i_op_a),
        .i_op_b   (i_op_b),
        .i_flush  (i_flush),
        .o_valid  (o_valid),
        .i_ready  (i_ready),
        .o_result (o_result),
        .o_busy   (o_busy)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check_output(input string tag, input logic [63:0] got, input logic [63:0] exp);
        check_cnt++;
        if (got === exp)
            pass_cnt++;
        else
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Reference arithmetic straight from the RV32M definitions.
    function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        int                ia, ib;
        longint            la, lb;
        longint unsigned   ua, ub;
        logic [63:0]       p;
        ia = $signed(a);
        ib = $signed(b);
        la = longint'(ia);
        lb = longint'(ib);
        ua = {32'h0, a};
        ub = {32'h0, b};
        case (op)
            3'd0: begin p = la * lb;            return p[31:0];  end
            3'd1: begin p = la * lb;            return p[63:32]; end
            3'd2: begin p = la * longint'(ub);  return p[63:32]; end
            3'd3: begin p = ua * ub;            return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                return 32'(ia / ib);
            end
            3'd5: begin
                if (b == 0) return 32'hFFFF_FFFF;
                return a / b;
            end
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                return 32'(ia % ib);
            end
            default: begin
                if (b == 0) return a;
                return a % b;
            end
        endcase
    endfunction

    function automatic int exp_latency(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        if (op[2]) begin
            if (b == 0) return 1;
            if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
            return 33;
        end
`ifdef MULDIV_FAST_MUL_EN
        return 1;
`else
        return 33;
`endif
    endfunction

    // Present one request for exactly the accept edge, then scramble the operand pins.
    task automatic apply_stimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        i_valid = 1'b1;
        i_op    = op;
        i_op_a  = a;
        i_op_b  = b;
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        i_op    = 3'($urandom);
        i_op_a  = $urandom;
        i_op_b  = $urandom;
    endtask

    task automatic await_result(input string tag, input logic [31:0] exp, input int exp_lat, input int hold);
        int          n;
        logic [31:0] held;
        logic        ok;
        n = 1;
        while (!o_valid && n < 200) begin
            @(posedge i_clk); #1;
            n++;
        end
        check_output({tag, " latency"}, 64'(n), 64'(exp_lat));
        check_output({tag, " result"}, 64'(o_result), 64'(exp));
        held = o_result;
        ok   = 1'b1;
        repeat (hold) begin
            @(posedge i_clk); #1;
            if (o_result !== held || o_ready !== 1'b0 || o_valid !== 1'b1)
                ok = 1'b0;
        end
        if (hold > 0)
            check_output({tag, " hold"}, 64'(ok), 64'(1));
        i_ready = 1'b1;
        @(posedge i_clk); #1;
        i_ready = 1'b0;
        check_output({tag, " ready_after"}, 64'({o_ready, o_valid}), 64'(2'b10));
    endtask

    logic [2:0]  d_op  [12] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7, 3'd4, 3'd7, 3'd4, 3'd6};
    logic [31:0] d_a   [12] = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9,
                                32'hFFFF_FFF9, 32'd100, 32'd100, 32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] d_b   [12] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2,
                                32'd2, 32'd7, 32'd7, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] d_exp [12] = '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFD,
                                32'hFFFF_FFFF, 32'd14, 32'd2, 32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic        seen;
        logic [2:0]  op;
        logic [31:0] a, b;
        int          sel;

        i_rst_n = 1'b0;
        i_valid = 1'b0;
        i_op    = 3'd0;
        i_op_a  = '0;
        i_op_b  = '0;
        i_flush = 1'b0;
        i_ready = 1'b0;
        repeat (3) @(posedge i_clk);
        #1;
        check_output("reset o_valid",  64'(o_valid),  64'(0));
        check_output("reset o_result", 64'(o_result), 64'(0));
        check_output("reset o_busy",   64'(o_busy),   64'(0));
        check_output("reset o_ready",  64'(o_ready),  64'(1));
        i_rst_n = 1'b1;
        @(posedge i_clk); #1;

        // Directed cases; DIVU 100/7 also exercises 5 cycles of backpressure.
        for (int k = 0; k < 12; k++) begin
            apply_stimulus(d_op[k], d_a[k], d_b[k]);
            await_result($sformatf("dir%0d", k), d_exp[k], exp_latency(d_op[k], d_a[k], d_b[k]),
                         (k == 6) ? 5 : 0);
        end

        // Flush a DIVU at T+10, confirm it never completes, then run MUL 3*4.
        apply_stimulus(3'd5, 32'd1000, 32'd3);
        repeat (9) @(posedge i_clk);
        #1;
        check_output("flush busy_before", 64'({o_busy, o_valid}), 64'(2'b10));
        i_flush = 1'b1;
        @(posedge i_clk); #1;
        i_flush = 1'b0;
        check_output("flush ready_t11", 64'({o_ready, o_valid}), 64'(2'b10));
        seen = 1'b0;
        repeat (40) begin
            @(posedge i_clk); #1;
            if (o_valid) seen = 1'b1;
        end
        check_output("flush no_valid", 64'(seen), 64'(0));
        apply_stimulus(3'd0, 32'd3, 32'd4);
        await_result("flush_mul", 32'd12, exp_latency(3'd0, 32'd3, 32'd4), 0);

        // Asynchronous reset in the middle of an iterative divide.
        apply_stimulus(3'd4, 32'd1000, 32'd7);
        repeat (5) @(posedge i_clk);
        #1;
        check_output("rst busy_before", 64'(o_busy), 64'(1));
        #2;
        i_rst_n = 1'b0;
        #1;
        check_output("rst async o_valid",  64'(o_valid),  64'(0));
        check_output("rst async o_ready",  64'(o_ready),  64'(1));
        check_output("rst async o_busy",   64'(o_busy),   64'(0));
        check_output("rst async o_result", 64'(o_result), 64'(0));
        @(posedge i_clk); #1;
        i_rst_n = 1'b1;
        seen = 1'b0;
        repeat (40) begin
            @(posedge i_clk); #1;
            if (o_valid) seen = 1'b1;
        end
        check_output("rst no_valid", 64'(seen), 64'(0));

        // Random operations with occasional special-case operands and backpressure.
        for (int k = 0; k < 40; k++) begin
            op  = 3'($urandom_range(0, 7));
            a   = $urandom;
            b   = $urandom;
            sel = $urandom_range(0, 9);
            if (sel == 0) b = 32'h0;
            if (sel == 1) begin
                a = 32'h8000_0000;
                b = 32'hFFFF_FFFF;
            end
            if (sel == 2) b = 32'($urandom_range(1, 300));
            apply_stimulus(op, a, b);
            await_result($sformatf("rnd%0d op%0d", k, op), ref_model(op, a, b),
                         exp_latency(op, a, b), $urandom_range(0, 2));
        end

        $display("[TB] %0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Parametrised multi-cycle multiply/divide unit implementing the RV32M/RV64M operation set next to the combinational ALU in the EX stage. Operands are accepted through a valid/ready handshake. An iterative one-bit-per-cycle datapath produces the result. The result is held until the consumer takes it, and a flush input lets the pipeline abandon an in-flight operation on a redirect.

## Interface
- XLEN, 32, operand/result width; legal values 32 or 64
- i_clk  in  1  clock, rising edge
- i_rst_n  in  1  reset, asynchronous, active-low
- i_valid  in  1  request valid
- o_ready  out  1  unit can accept a request (high only in IDLE)
- i_op  in  3  funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
- i_op_a  in  XLEN  rs1 operand (multiplicand / dividend)
- i_op_b  in  XLEN  rs2 operand (multiplier / divisor)
- i_flush  in  1  abort current operation
- o_valid  out  1  result valid
- i_ready  in  1  consumer accepts result
- o_result  out  XLEN  result
- o_busy  out  1  state != IDLE

## Operation
- States: IDLE, CALC, DONE.
- **IDLE:**
  - A request is accepted when i_valid & o_ready & ~i_flush.
  - On accept, the unit latches i_op and latches operand magnitudes. Signed ops take the two's-complement magnitude of negative operands. MULHSU treats only a as signed.
  - It also records the result sign:
    - MUL*: sign = sa ^ sb.
    - DIV: sign = sa ^ sb.
    - REM: sign = sa.
- **Special cases** (decided in IDLE, go straight to DONE):
  - Divisor 0: DIV/DIVU give all-ones; REM/REMU give i_op_a.
  - DIV/REM with a = 1<<(XLEN-1) and b = all-ones: DIV gives a, REM gives 0.
- **CALC:**
  - Counter runs 0..XLEN-1, one step per cycle.
  - Multiply: shift-add into a 2*XLEN accumulator.
  - Divide: restoring shift-subtract. The remainder is kept XLEN+1 bits wide; a quotient bit is 1 when the trial difference is non-negative.
  - When the counter reaches XLEN-1, the unit applies the recorded sign (conditional two's-complement negate), selects the low half (MUL), high half (MULH*), quotient or remainder, registers o_result, and moves to DONE.
- **DONE:**
  - o_valid = 1 and o_result is stable.
  - On i_ready, the unit returns to IDLE.
- **i_flush:** any state → IDLE on the next edge; o_valid drops; the result is discarded. Flush overrides accept and i_ready.
- All arithmetic is modulo 2^XLEN, except the 2*XLEN product and the XLEN+1 remainder.

## Timing
- Reset values: state IDLE, o_valid 0, o_result 0, o_busy 0, o_ready 1.
- Request accepted in cycle T:
  - o_valid high from cycle T+XLEN+1 (iterative ops).
  - o_valid high from cycle T+1 (special cases).
- o_valid, once high, stays high with o_result unchanged until an i_ready or i_flush edge.
- After a handshake in cycle U, o_ready is high in U+1. There is no same-cycle result-out / request-in overlap.
- o_ready is a pure decode of state; it does not depend on i_valid.
- i_op, i_op_a and i_op_b are sampled only on the accept edge; later changes are ignored.
- Asynchronous reset mid-CALC: outputs go to reset values immediately, and no result is produced.

## Configuration
- MULDIV_FAST_MUL_EN:
  - Defined: MUL/MULH/MULHSU/MULHU use a single-cycle XLEN×XLEN product, registered on accept, so o_valid is high at T+1. Divides remain iterative.
  - Undefined: all multiplies take the iterative path with XLEN+1 latency, and no multiplier array is inferred.

## Structure
- Package muldiv_pkg holds:
  - the op enum (funct3 encodings above) and the state enum (IDLE/CALC/DONE);
  - the default XLEN;
  - a helper function that detects the special cases.
- One sub-module: addsub_n, an XLEN+1-bit parametrised adder/subtractor.
  - It is shared by the multiply accumulate step, the divide trial-subtract and the final sign negate.
  - It is selected by mode in each state, matching the single-adder style of the ALU.

## Test plan
- **MUL** 7 × 0xFFFFFFFD (XLEN=32): o_result 0xFFFFFFEB. o_valid first seen at T+33, or T+1 with MULDIV_FAST_MUL_EN.
- **High-half multiplies:**
  - MULH 0x80000000 × 0x80000000 → 0x40000000.
  - MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
- **Divides:**
  - DIV 0xFFFFFFF9 / 2 → 0xFFFFFFFD; REM with the same operands → 0xFFFFFFFF.
  - DIVU 100 / 7 → 14; REMU 100 / 7 → 2.
- **Special cases:**
  - DIV 5 / 0 → 0xFFFFFFFF at T+1.
  - REMU 5 / 0 → 5.
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000.
  - REM 0x80000000 / 0xFFFFFFFF → 0.
- **Backpressure:** hold i_ready=0 for 5 cycles after o_valid. Require o_result stable and o_ready low throughout, then o_ready high the cycle after i_ready=1.
- **Flush and reset:**
  - Assert i_flush at T+10 of a DIVU: o_valid never rises and o_ready is 1 at T+11. A new MUL 3 × 4 is then accepted → 12.
  - Drop i_rst_n mid-CALC: all outputs go to reset values asynchronously.
